// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch0 address generator.
package fetch_pkg;

  localparam int unsigned ADDR_W          = 30;
  localparam int unsigned ASID_W          = 9;
  localparam int unsigned MAX_FETCH_WORDS = 8;
  localparam int unsigned MAX_EPOCH_BITS  = 8;
  localparam int unsigned OFF_W           = 3;

  // Redirect source priority: lower index wins.
  typedef enum int unsigned {
    REDIR_CSR = 0,
    REDIR_DE  = 1
  } redir_src_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_INHIBIT = 2'd2
  } fe0_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]          addr;
    logic [MAX_FETCH_WORDS-1:0] mask;
    logic [MAX_EPOCH_BITS-1:0]  epoch;
    logic                       spec;
  } fetch_req_t;

  // Words at or above the entry offset within the block are live.
  function automatic logic [MAX_FETCH_WORDS-1:0] word_mask(input logic [OFF_W-1:0] off);
    return ~((MAX_FETCH_WORDS'(1) << off) - MAX_FETCH_WORDS'(1));
  endfunction

endpackage

// File: rtl/fetch_redir_arb.sv
// Fixed-priority one-hot select over redirect sources; index 0 wins.
module fetch_redir_arb #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant,
  output logic         any
);

  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (valid[i] && !any) begin
        grant[i] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_pcgen.sv
// Fetch0 address generator: one aligned multi-word icache request per cycle,
// prioritised redirects with stall buffering, epoch and speculation tagging.
module fetch_pcgen
  import fetch_pkg::*;
#(
  parameter int unsigned FETCH_WORDS  = 2,
  parameter int unsigned NUM_REDIRECT = 2,
  parameter int unsigned EPOCH_BITS   = 3,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                           clk_core,
  input  logic                           reset,
  input  logic                           fe1_stall,
  input  logic                           csr_fe_inhibit,
  input  logic [31:0]                    csr_satp,
  input  logic [NUM_REDIRECT-1:0]        redir_valid,
  input  logic [NUM_REDIRECT*ADDR_W-1:0] redir_pc,
  input  logic [NUM_REDIRECT-1:0]        redir_spec,
  input  logic                           spec_resolve,
  output logic                           fe0_read_req,
  output logic                           fe0_valid,
  output logic [ADDR_W-1:0]              fe0_read_addr,
  output logic [FETCH_WORDS-1:0]         fe0_read_mask,
  output logic [ASID_W-1:0]              fe0_read_asid,
  output logic [EPOCH_BITS-1:0]          fe0_epoch,
  output logic                           fe0_speculative
);

  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(FETCH_WORDS - 1);

  fe0_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [ADDR_W-1:0]       pend_pc_q, pend_pc_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    pend_spec_q, pend_spec_d;
  logic [EPOCH_BITS-1:0]   epoch_q, epoch_d;
  logic                    spec_q, spec_d;

  logic [NUM_REDIRECT-1:0] sel_grant;
  logic                    sel_any;
  logic [ADDR_W-1:0]       sel_pc;
  logic                    sel_spec;
  logic                    have_pend;
  logic                    issue;
  logic [ADDR_W-1:0]       target;
  logic [ADDR_W-1:0]       blk_addr;
  logic [OFF_W-1:0]        off;
  fetch_req_t              req;

  fetch_redir_arb #(.N(NUM_REDIRECT)) u_arb (
    .valid (redir_valid),
    .grant (sel_grant),
    .any   (sel_any)
  );

  // One-hot mux of the winning source's target and speculative bit.
  always_comb begin
    sel_pc   = '0;
    sel_spec = 1'b0;
    for (int i = 0; i < int'(NUM_REDIRECT); i++) begin
      if (sel_grant[i]) begin
        sel_pc   = redir_pc[i*ADDR_W +: ADDR_W];
        sel_spec = redir_spec[i];
      end
    end
  end

  always_comb begin
    state_d      = ST_RUN;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    pend_spec_d  = pend_spec_q;
    epoch_d      = epoch_q;
    spec_d       = spec_q;
    req          = '0;

    have_pend = pend_valid_q && (state_q != ST_RUN);
    issue     = ~fe1_stall & ~csr_fe_inhibit & ~reset;
    target    = sel_any ? sel_pc : (have_pend ? pend_pc_q : pc_q);
    blk_addr  = target & ~BLK_MASK;
    off       = OFF_W'(target & BLK_MASK);

    // A live redirect bumps the epoch; resolve only clears non-redirect speculation.
    if (sel_any) begin
      epoch_d = epoch_q + EPOCH_BITS'(1);
      spec_d  = sel_spec;
    end else begin
      spec_d      = (have_pend ? pend_spec_q : spec_q) & ~spec_resolve;
      pend_spec_d = pend_spec_q & ~spec_resolve;
    end

    if (issue) begin
      pc_d         = blk_addr + ADDR_W'(FETCH_WORDS);
      pend_valid_d = 1'b0;
    end else if (sel_any) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = sel_pc;
      pend_spec_d  = sel_spec;
    end

    if (csr_fe_inhibit) begin
      state_d = ST_INHIBIT;
    end else if (pend_valid_d) begin
      state_d = ST_HOLD;
    end

    req.addr = blk_addr;
    if (!reset) begin
      req.mask  = word_mask(off);
      req.epoch = MAX_EPOCH_BITS'(epoch_d);
      req.spec  = spec_d;
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC[31:2];
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_spec_q  <= 1'b0;
      epoch_q      <= '0;
      spec_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_spec_q  <= pend_spec_d;
      epoch_q      <= epoch_d;
      spec_q       <= spec_d;
    end
  end

  assign fe0_read_req    = issue;
  assign fe0_valid       = issue;
  assign fe0_read_addr   = req.addr;
  assign fe0_read_mask   = req.mask[FETCH_WORDS-1:0];
  assign fe0_read_asid   = csr_satp[30:22];
  assign fe0_epoch       = req.epoch[EPOCH_BITS-1:0];
  assign fe0_speculative = req.spec;

  // Struct upper lanes and non-ASID satp bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{req, csr_satp[31], csr_satp[21:0]};

endmodule

// File: tb/tb_fetch_pcgen.sv
// Scoreboard bench for fetch_pcgen: stimulus queues expected requests,
// a negedge monitor pops and compares whenever a request is presented.
module tb_fetch_pcgen;

  logic        clk_core = 1'b0;
  logic        reset;
  logic        fe1_stall;
  logic        csr_fe_inhibit;
  logic [31:0] csr_satp;
  logic [1:0]  redir_valid;
  logic [59:0] redir_pc;
  logic [1:0]  redir_spec;
  logic        spec_resolve;
  logic        fe0_read_req;
  logic        fe0_valid;
  logic [29:0] fe0_read_addr;
  logic [1:0]  fe0_read_mask;
  logic [8:0]  fe0_read_asid;
  logic [2:0]  fe0_epoch;
  logic        fe0_speculative;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  mask;
    logic [2:0]  epoch;
    logic        spec;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  localparam logic [8:0] EXP_ASID = 9'h048;

  fetch_pcgen #(
    .FETCH_WORDS  (2),
    .NUM_REDIRECT (2),
    .EPOCH_BITS   (3),
    .RESET_PC     (32'h0000_0100)
  ) dut (
    .clk_core        (clk_core),
    .reset           (reset),
    .fe1_stall       (fe1_stall),
    .csr_fe_inhibit  (csr_fe_inhibit),
    .csr_satp        (csr_satp),
    .redir_valid     (redir_valid),
    .redir_pc        (redir_pc),
    .redir_spec      (redir_spec),
    .spec_resolve    (spec_resolve),
    .fe0_read_req    (fe0_read_req),
    .fe0_valid       (fe0_valid),
    .fe0_read_addr   (fe0_read_addr),
    .fe0_read_mask   (fe0_read_mask),
    .fe0_read_asid   (fe0_read_asid),
    .fe0_epoch       (fe0_epoch),
    .fe0_speculative (fe0_speculative)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: reset values while in reset, otherwise compare each presented request.
  always @(negedge clk_core) begin
    if (reset) begin
      chk("rst_req",   32'(fe0_read_req),    32'd0);
      chk("rst_mask",  32'(fe0_read_mask),   32'd0);
      chk("rst_epoch", 32'(fe0_epoch),       32'd0);
      chk("rst_spec",  32'(fe0_speculative), 32'd0);
    end else if (fe0_read_req) begin
      chk("valid_eq_req", 32'(fe0_valid), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got request at %h expected none", {fe0_read_addr, 2'b00});
      end else begin
        mon_e = exp_q.pop_front();
        chk("addr",  {fe0_read_addr, 2'b00},  mon_e.addr);
        chk("mask",  32'(fe0_read_mask),      32'(mon_e.mask));
        chk("epoch", 32'(fe0_epoch),          32'(mon_e.epoch));
        chk("spec",  32'(fe0_speculative),    32'(mon_e.spec));
        chk("asid",  32'(fe0_read_asid),      32'(EXP_ASID));
      end
    end else begin
      chk("idle_valid", 32'(fe0_valid), 32'd0);
    end
  end

  task automatic redir(input int idx, input logic [31:0] byte_addr, input logic sp);
    redir_valid[idx]          = 1'b1;
    redir_pc[idx*30 +: 30]    = byte_addr[31:2];
    redir_spec[idx]           = sp;
  endtask

  // Advance one cycle, queueing the request expected in the current cycle.
  task automatic go(input logic exp_v, input logic [31:0] a, input logic [1:0] m,
                    input logic [2:0] ep, input logic sp);
    exp_t e;
    if (exp_v) begin
      e.addr  = a;
      e.mask  = m;
      e.epoch = ep;
      e.spec  = sp;
      exp_q.push_back(e);
    end
    @(posedge clk_core);
    #1;
    redir_valid  = '0;
    redir_spec   = '0;
    redir_pc     = '0;
    spec_resolve = 1'b0;
  endtask

  task automatic idle();
    go(1'b0, 32'h0, 2'b00, 3'd0, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    fe1_stall      = 1'b0;
    csr_fe_inhibit = 1'b0;
    csr_satp       = 32'h1234_5678;
    redir_valid    = '0;
    redir_pc       = '0;
    redir_spec     = '0;
    spec_resolve   = 1'b0;
    @(posedge clk_core);
    #1;

    // Reset, with a redirect that must be ignored
    idle();
    redir(1, 32'h500, 1'b0);
    idle();
    idle();
    reset = 1'b0;

    go(1'b1, 32'h100, 2'b11, 3'd0, 1'b0);
    go(1'b1, 32'h108, 2'b11, 3'd0, 1'b0);

    // Unaligned redirect
    redir(1, 32'h10C, 1'b0);
    go(1'b1, 32'h108, 2'b10, 3'd1, 1'b0);
    go(1'b1, 32'h110, 2'b11, 3'd1, 1'b0);

    // Redirect captured during a 3-cycle stall
    fe1_stall = 1'b1;
    redir(1, 32'h200, 1'b0);
    idle();
    idle();
    idle();
    fe1_stall = 1'b0;
    go(1'b1, 32'h200, 2'b11, 3'd2, 1'b0);
    go(1'b1, 32'h208, 2'b11, 3'd2, 1'b0);

    // CSR beats speculative decode
    redir(0, 32'h80, 1'b0);
    redir(1, 32'h400, 1'b1);
    go(1'b1, 32'h080, 2'b11, 3'd3, 1'b0);
    go(1'b1, 32'h088, 2'b11, 3'd3, 1'b0);

    // Speculative path then resolve
    redir(1, 32'h300, 1'b1);
    go(1'b1, 32'h300, 2'b11, 3'd4, 1'b1);
    go(1'b1, 32'h308, 2'b11, 3'd4, 1'b1);
    spec_resolve = 1'b1;
    go(1'b1, 32'h310, 2'b11, 3'd4, 1'b0);
    go(1'b1, 32'h318, 2'b11, 3'd4, 1'b0);

    // Pending redirect overwritten by a later CSR redirect
    fe1_stall = 1'b1;
    redir(1, 32'h600, 1'b0);
    idle();
    redir(0, 32'h700, 1'b0);
    idle();
    fe1_stall = 1'b0;
    go(1'b1, 32'h700, 2'b11, 3'd6, 1'b0);
    go(1'b1, 32'h708, 2'b11, 3'd6, 1'b0);

    // Redirect captured while inhibited
    csr_fe_inhibit = 1'b1;
    redir(1, 32'h900, 1'b0);
    idle();
    idle();
    csr_fe_inhibit = 1'b0;
    go(1'b1, 32'h900, 2'b11, 3'd7, 1'b0);
    go(1'b1, 32'h908, 2'b11, 3'd7, 1'b0);

    // Live redirect beats pending on stall release; epoch wraps 7->0->1
    fe1_stall = 1'b1;
    redir(1, 32'hA00, 1'b0);
    idle();
    fe1_stall = 1'b0;
    redir(0, 32'hB04, 1'b0);
    go(1'b1, 32'hB00, 2'b10, 3'd1, 1'b0);
    go(1'b1, 32'hB08, 2'b11, 3'd1, 1'b0);

    // Eight back-to-back redirects: epoch comes full circle
    for (int k = 0; k < 8; k++) begin
      redir(1, 32'h1000 + 32'(k) * 32'h10, 1'b0);
      go(1'b1, 32'h1000 + 32'(k) * 32'h10, 2'b11, 3'(2 + k), 1'b0);
    end
    go(1'b1, 32'h1078, 2'b11, 3'd1, 1'b0);

    // PC wrap at the top of the address space
    redir(1, 32'hFFFF_FFF8, 1'b0);
    go(1'b1, 32'hFFFF_FFF8, 2'b11, 3'd2, 1'b0);
    go(1'b1, 32'h0000_0000, 2'b11, 3'd2, 1'b0);

    // Reset while holding a pending redirect discards it
    fe1_stall = 1'b1;
    redir(1, 32'hC00, 1'b0);
    idle();
    reset     = 1'b1;
    fe1_stall = 1'b0;
    idle();
    idle();
    reset = 1'b0;
    go(1'b1, 32'h100, 2'b11, 3'd0, 1'b0);
    go(1'b1, 32'h108, 2'b11, 3'd0, 1'b0);

    fe1_stall = 1'b1;
    idle();
    idle();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
